uart_sender: RTL and testbench

UART_SENDER -- requirements
Module: uart_sender

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 49 ++++
 rtl/uart_sender.sv | 159 +++++++++++++++
 tb/tb_uart_sender.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, data width and bit-period divisor,
// common to the transmitter and the future receiver.
package uart_pkg;

   localparam int DATA_W = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   function automatic int uart_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 while enabled and emits a one-cycle
// bit_tick on the last count of every bit period.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV = 434
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clr_i,
   input  logic en_i,
   output logic bit_tick_o
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_s;

   assign wrap_s     = (cnt_q == LAST);
   assign bit_tick_o = en_i & wrap_s;

   // Next count: a fresh frame restarts the period from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (en_i) begin
         if (wrap_s) begin
            cnt_d = {CNT_W{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_sender.sv
// UART transmitter: 8 data bits LSB first, one stop bit, line idles high.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_sender
   import uart_pkg::*;
#(
   parameter int bandRate   = 115200,
   parameter int clockSpeed = 50_000_000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] data_send,
   input  logic       data_send_trig,
   output logic       uart_tx,
   output logic       busy,
   output logic       send_done
);

   localparam int DIV = uart_div(clockSpeed, bandRate);

   logic [2:0]        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [2:0]        idx_q, idx_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept_s;
   logic              bit_tick_s;
`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   assign accept_s = (state_q == ST_IDLE) & data_send_trig;

   uart_baud_gen #(
      .DIV (DIV)
   ) u_baud (
      .clock      (clock),
      .reset_n    (reset_n),
      .clr_i      (accept_s),
      .en_i       (busy_q),
      .bit_tick_o (bit_tick_s)
   );

   // Frame sequencing; tx_d is the line level for the cycle after the edge.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (data_send_trig) begin
               state_d = ST_START;
               shift_d = data_send;
               idx_d   = 3'd0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
               parity_d = even_parity(data_send);
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (bit_tick_s) begin
               state_d = ST_DATA;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[DATA_W-1:1]};
               idx_d   = 3'd0;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_tick_s) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  tx_d    = parity_q;
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  state_d = ST_DATA;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[DATA_W-1:1]};
               end
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_tick_s) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end else begin
               state_d = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (bit_tick_s) begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset parks the line high immediately.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         shift_q <= {DATA_W{1'b0}};
         idx_q   <= 3'd0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign uart_tx   = tx_q;
   assign busy      = busy_q;
   assign send_done = done_q;

endmodule

// File: tb/tb_uart_sender.sv
// Self-checking bench for uart_sender: a per-cycle frame model plus directed
// scenarios with hand-computed expectations. Honours UART_TX_PARITY_EN.
module tb_uart_sender;

   localparam int DIV = 50_000_000 / 115200;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS       = 11;
   localparam int DONE_LIT    = 4775;
   localparam int BUSY_LIT    = 4774;
   localparam int DONE2_LIT   = 9550;
   localparam int SMALL_LEN   = 33;
   localparam logic [10:0] SMALL_PAT = 11'b10010101010;
`else
   localparam int NBITS       = 10;
   localparam int DONE_LIT    = 4341;
   localparam int BUSY_LIT    = 4340;
   localparam int DONE2_LIT   = 8682;
   localparam int SMALL_LEN   = 30;
   localparam logic [10:0] SMALL_PAT = 11'b01010101010;
`endif
   localparam int FRAME   = NBITS * DIV;
   localparam int CAP_MAX = 10000;

   typedef struct packed {
      logic tx;
      logic busy;
      logic done;
   } obs_t;
   localparam obs_t IDLE_OBS = 3'b100;

   logic       clock          = 1'b0;
   logic       reset_n        = 1'b0;
   logic [7:0] data_send      = 8'h00;
   logic       data_send_trig = 1'b0;
   logic       uart_tx, busy, send_done;

   logic [7:0] s_data = 8'h00;
   logic       s_trig = 1'b0;
   logic       s_tx, s_busy, s_done;

   int checks = 0;
   int errors = 0;

   uart_sender dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .data_send      (data_send),
      .data_send_trig (data_send_trig),
      .uart_tx        (uart_tx),
      .busy           (busy),
      .send_done      (send_done)
   );

   uart_sender #(.bandRate(300), .clockSpeed(1000)) u_small (
      .clock          (clock),
      .reset_n        (reset_n),
      .data_send      (s_data),
      .data_send_trig (s_trig),
      .uart_tx        (s_tx),
      .busy           (s_busy),
      .send_done      (s_done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Behavioural model: an accepted byte becomes a list of per-cycle line states.
   obs_t exp_q[$];
   obs_t exp_now     = IDLE_OBS;
   logic model_valid = 1'b0;

   function automatic void push_frame(input logic [7:0] d);
      logic slot [NBITS];
      slot[0] = 1'b0;
      for (int i = 0; i < 8; i++) slot[i+1] = d[i];
      if (NBITS == 11) slot[9] = ^d;
      slot[NBITS-1] = 1'b1;
      for (int b = 0; b < NBITS; b++)
         for (int c = 0; c < DIV; c++)
            exp_q.push_back(obs_t'{tx: slot[b], busy: 1'b1, done: 1'b0});
      exp_q.push_back(obs_t'{tx: 1'b1, busy: 1'b0, done: 1'b1});
   endfunction

   initial begin
      forever begin
         @(posedge clock);
         if (!reset_n) begin
            exp_q.delete();
            exp_now = IDLE_OBS;
         end else begin
            if (exp_q.size() == 0 && data_send_trig) push_frame(data_send);
            if (exp_q.size() != 0) exp_now = exp_q.pop_front();
            else                   exp_now = IDLE_OBS;
         end
         model_valid = 1'b1;
      end
   end

   always @(negedge clock) begin
      if (model_valid) begin
         checks++;
         if ({uart_tx, busy, send_done} !== exp_now) begin
            errors++;
            $display("FAIL model_cmp t=%0t actual=%b required=%b", $time,
                     {uart_tx, busy, send_done}, exp_now);
         end
      end
   end

   // Capture buffer: index n is the cycle after the n-th edge following acceptance.
   logic cap_tx   [CAP_MAX+1];
   logic cap_busy [CAP_MAX+1];
   logic cap_done [CAP_MAX+1];

   task automatic capture(input int n);
      for (int i = 1; i <= n; i++) begin
         @(negedge clock);
         cap_tx[i]   = uart_tx;
         cap_busy[i] = busy;
         cap_done[i] = send_done;
      end
   endtask

   task automatic run_frame(input logic [7:0] d, input int ncap);
      @(negedge clock);
      data_send      = d;
      data_send_trig = 1'b1;
      fork
         capture(ncap);
         begin
            @(negedge clock);
            data_send_trig = 1'b0;
            data_send      = ~d;
         end
      join
   endtask

   function automatic logic [7:0] decode(input int base);
      logic [7:0] b;
      for (int k = 0; k < 8; k++) b[k] = cap_tx[base + (k + 1) * DIV + DIV / 2];
      return b;
   endfunction

   function automatic int count_busy(input int lo, input int hi);
      int c = 0;
      for (int i = lo; i <= hi; i++) if (cap_busy[i] === 1'b1) c++;
      return c;
   endfunction

   function automatic int count_done(input int lo, input int hi);
      int c = 0;
      for (int i = lo; i <= hi; i++) if (cap_done[i] === 1'b1) c++;
      return c;
   endfunction

   function automatic int first_done(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) if (cap_done[i] === 1'b1) return i;
      return -1;
   endfunction

   initial begin
      #5ms;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic [10:0] pat_v;

      repeat (4) @(negedge clock);
      check("rst_tx", uart_tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", send_done, 1'b0);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);

      // 0x55 right after reset release
      run_frame(8'h55, FRAME + 5);
      check("t55_latency_tx", cap_tx[1], 1'b0);
      check("t55_latency_busy", cap_busy[1], 1'b1);
      check("t55_start", cap_tx[1 + DIV / 2], 1'b0);
      check("t55_byte", decode(1), 8'h55);
      check("t55_stop", cap_tx[1 + (NBITS - 1) * DIV + DIV / 2], 1'b1);
      check("t55_done_at", first_done(1, FRAME + 5), DONE_LIT);
      check("t55_busy_cycles", count_busy(1, FRAME + 5), BUSY_LIT);
      check("t55_busy_last", cap_busy[DONE_LIT - 1], 1'b1);
      check("t55_busy_fall", cap_busy[DONE_LIT], 1'b0);
      check("t55_done_width", count_done(1, FRAME + 5), 1);

      // 0xA3 with an ignored 0xFF trigger at cycle 2000
      @(negedge clock);
      data_send      = 8'hA3;
      data_send_trig = 1'b1;
      fork
         capture(FRAME + 20);
         begin
            @(negedge clock);
            data_send_trig = 1'b0;
            repeat (1999) @(negedge clock);
            data_send      = 8'hFF;
            data_send_trig = 1'b1;
            @(negedge clock);
            data_send_trig = 1'b0;
         end
      join
      check("a3_byte", decode(1), 8'hA3);
      check("a3_done_at", first_done(1, FRAME + 20), DONE_LIT);
      check("a3_single_frame", count_done(1, FRAME + 20), 1);
      check("a3_idle_tx", cap_tx[FRAME + 15], 1'b1);
      check("a3_idle_busy", cap_busy[FRAME + 15], 1'b0);

      // trigger held high: 0x00 then 0x81 back to back
      @(negedge clock);
      data_send      = 8'h00;
      data_send_trig = 1'b1;
      fork
         capture(2 * (FRAME + 1) + 10);
         begin
            @(negedge clock);
            data_send = 8'h81;
            repeat (FRAME + 1) @(negedge clock);
            data_send_trig = 1'b0;
            data_send      = 8'h7E;
         end
      join
      check("b2b_first_byte", decode(1), 8'h00);
      check("b2b_second_start", cap_tx[DONE_LIT + 1], 1'b0);
      check("b2b_second_busy", cap_busy[DONE_LIT + 1], 1'b1);
      check("b2b_second_byte", decode(DONE_LIT + 1), 8'h81);
      check("b2b_done_count", count_done(1, 2 * (FRAME + 1) + 10), 2);
      check("b2b_done2_at", first_done(DONE_LIT + 1, 2 * (FRAME + 1) + 10), DONE2_LIT);

      // reset pulse at cycle 1500 of a frame
      @(negedge clock);
      data_send      = 8'hC3;
      data_send_trig = 1'b1;
      fork
         capture(1510);
         begin
            @(negedge clock);
            data_send_trig = 1'b0;
            repeat (1499) @(negedge clock);
            reset_n = 1'b0;
            @(negedge clock);
            reset_n = 1'b1;
         end
      join
      check("rstmid_tx", cap_tx[1501], 1'b1);
      check("rstmid_busy", cap_busy[1501], 1'b0);
      check("rstmid_no_done", count_done(1, 1510), 0);
      run_frame(8'h3C, FRAME + 5);
      check("post_rst_byte", decode(1), 8'h3C);
      check("post_rst_done_at", first_done(1, FRAME + 5), DONE_LIT);

      // parity slot: 0x07 (three ones) then 0x03 (two ones)
      run_frame(8'h07, FRAME + 5);
`ifdef UART_TX_PARITY_EN
      check("p07_parity", cap_tx[1 + 9 * DIV + DIV / 2], 1'b1);
      check("p07_busy_cycles", count_busy(1, FRAME + 5), 4774);
`else
      check("p07_stop_after_data", cap_tx[1 + 9 * DIV + DIV / 2], 1'b1);
      check("p07_busy_cycles", count_busy(1, FRAME + 5), 4340);
`endif
      check("p07_byte", decode(1), 8'h07);
      run_frame(8'h03, FRAME + 5);
`ifdef UART_TX_PARITY_EN
      check("p03_parity", cap_tx[1 + 9 * DIV + DIV / 2], 1'b0);
`else
      check("p03_stop_after_data", cap_tx[1 + 9 * DIV + DIV / 2], 1'b1);
`endif
      check("p03_byte", decode(1), 8'h03);

      // DIV = 3 instance: every bit exactly three cycles
      pat_v = SMALL_PAT;
      @(negedge clock);
      s_data = 8'h55;
      s_trig = 1'b1;
      for (int n = 1; n <= SMALL_LEN; n++) begin
         @(negedge clock);
         if (n == 1) s_trig = 1'b0;
         check("small_bit", s_tx, pat_v[(n - 1) / 3]);
         check("small_busy", s_busy, 1'b1);
      end
      @(negedge clock);
      check("small_done", s_done, 1'b1);
      check("small_busy_fall", s_busy, 1'b0);

      repeat (5) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
